// File: rtl/dnn_pkg.sv
// Shared types and helpers for the dense-network output stages.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } argmax_state_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dnn_argmax.sv
// Classification head: captures a score vector, scans it one element per cycle
// for the largest signed score, and presents index/score on a valid/ready port.
module dnn_argmax
  import dnn_pkg::*;
#(
  parameter int BitSize    = 32,
  parameter int NumClasses = 2,
  parameter int CountBits  = 8,
  localparam int IdxBits   = idx_width(NumClasses)
) (
  input  logic                                 clk,
  input  logic                                 res_n,
  input  logic                                 in_valid,
  input  logic [NumClasses-1:0][BitSize-1:0]   in_data,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IdxBits-1:0]                   out_index,
  output logic [BitSize-1:0]                   out_max,
  output logic                                 out_last,
  output logic [CountBits-1:0]                 out_count
);

  localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NumClasses - 1);

  function automatic logic [CountBits-1:0] sat_inc(input logic [CountBits-1:0] c);
    return (c == '1) ? c : c + CountBits'(1);
  endfunction

  argmax_state_t                      state_q, state_d;
  logic [NumClasses-1:0][BitSize-1:0] vec_q, vec_d;
  logic                               last_q, last_d;
  logic [IdxBits-1:0]                 ptr_q, ptr_d;
  logic [IdxBits-1:0]                 best_idx_q, best_idx_d;
  logic signed [BitSize-1:0]          best_q, best_d;
  logic signed [BitSize-1:0]          cand;
  logic                               out_valid_q, out_valid_d;
  logic [IdxBits-1:0]                 out_index_q, out_index_d;
  logic signed [BitSize-1:0]          out_max_q, out_max_d;
  logic                               out_last_q, out_last_d;
  logic [CountBits-1:0]               count_q, count_d;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    last_d      = last_q;
    ptr_d       = ptr_q;
    best_idx_d  = best_idx_q;
    best_d      = best_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_max_d   = out_max_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    cand        = signed'(vec_q[ptr_q]);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d      = in_data;
          last_d     = in_last;
          best_d     = signed'(in_data[0]);
          best_idx_d = '0;
          ptr_d      = IdxBits'(1);
          state_d    = (NumClasses == 1) ? HOLD : SCAN;
        end
      end
      SCAN: begin
        // Strictly-greater replace keeps the lower index on ties.
        if (cand > best_q) begin
          best_d     = cand;
          best_idx_d = ptr_q;
        end
        if (ptr_q == LastIdx) begin
          state_d = HOLD;
        end else begin
          ptr_d = ptr_q + IdxBits'(1);
        end
      end
      HOLD: begin
        // First HOLD cycle publishes the result into the output registers.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_index_d = best_idx_q;
          out_max_d   = best_q;
          out_last_d  = last_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = sat_inc(count_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      best_idx_q  <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_max_q   <= '0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      best_idx_q  <= best_idx_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_max_q   <= out_max_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    vec_q  <= vec_d;
    best_q <= best_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_max   = out_max_q;
  assign out_last  = out_last_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_dnn_argmax.sv
// Scoreboard bench for dnn_argmax: a 6-class instance and a 1-class instance
// with a 2-bit counter, both checked against a plain argmax reference.
module tb_dnn_argmax;

  typedef struct {
    int idx;
    int mx;
    bit last;
    int cnt;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;

  // Instance A: six classes, 8-bit counter
  logic              rst_a = 1, in_valid_a = 0, in_last_a = 0, in_ready_a;
  logic [5:0][31:0]  in_data_a = '0;
  logic              out_valid_a, out_ready_a = 1, out_last_a;
  logic [2:0]        out_index_a;
  logic [31:0]       out_max_a;
  logic [7:0]        out_count_a;

  // Instance B: one class, 2-bit counter
  logic              rst_b = 1, in_valid_b = 0, in_last_b = 0, in_ready_b;
  logic [0:0][31:0]  in_data_b = '0;
  logic              out_valid_b, out_ready_b = 1, out_last_b;
  logic [0:0]        out_index_b;
  logic [31:0]       out_max_b;
  logic [1:0]        out_count_b;

  dnn_argmax #(.BitSize(32), .NumClasses(6), .CountBits(8)) dut_a (
    .clk(clk), .res_n(rst_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_last(in_last_a), .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_index(out_index_a), .out_max(out_max_a),
    .out_last(out_last_a), .out_count(out_count_a));

  dnn_argmax #(.BitSize(32), .NumClasses(1), .CountBits(2)) dut_b (
    .clk(clk), .res_n(rst_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_last(in_last_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_index(out_index_b), .out_max(out_max_b),
    .out_last(out_last_b), .out_count(out_count_b));

  exp_t qa[$], qb[$];
  int   na = 0, nb = 0;
  int   n_chk = 0, n_pass = 0;
  bit   rand_done = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic void ref_argmax(input int v[$], output int idx, output int mx);
    idx = 0;
    mx  = v[0];
    foreach (v[i]) if (v[i] > mx) begin mx = v[i]; idx = i; end
  endfunction

  function automatic int sat_cnt(input int k, input int maxv);
    return (k > maxv) ? maxv : k;
  endfunction

  function automatic int rnd_score();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  // Scoreboard monitors: compare at every handoff
  always @(negedge clk) begin
    if (!rst_a && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected: result idx %0d with empty queue", out_index_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_index", longint'(out_index_a), e.idx);
        chk("a_max", longint'($signed(out_max_a)), e.mx);
        chk("a_last", longint'(out_last_a), e.last);
        chk("a_count", longint'(out_count_a), e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected: result max %0d with empty queue", $signed(out_max_b));
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_index", longint'(out_index_b), e.idx);
        chk("b_max", longint'($signed(out_max_b)), e.mx);
        chk("b_last", longint'(out_last_b), e.last);
        chk("b_count", longint'(out_count_b), e.cnt);
      end
    end
  end

  task automatic check_reset_a(input string tag);
    chk({tag, "_in_ready"}, in_ready_a, 1);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_out_index"}, out_index_a, 0);
    chk({tag, "_out_max"}, out_max_a, 0);
    chk({tag, "_out_last"}, out_last_a, 0);
    chk({tag, "_out_count"}, out_count_a, 0);
  endtask

  task automatic reset_a(input string tag);
    @(posedge clk); #1;
    rst_a = 1;
    qa.delete();
    na = 0;
    @(posedge clk); #1;
    rst_a = 0;
    @(negedge clk);
    check_reset_a(tag);
  endtask

  task automatic wait_valid_a(input int n, input string tag);
    int lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!out_valid_a && lat < 100);
    chk({tag, "_latency"}, lat, n);
  endtask

  task automatic send_a(input int v[6], input bit last, input bit meas, input string tag);
    exp_t e;
    int vq[$];
    int guard = 0;
    for (int i = 0; i < 6; i++) vq.push_back(v[i]);
    ref_argmax(vq, e.idx, e.mx);
    e.last = last;
    e.cnt  = sat_cnt(na, 255);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) in_data_a[i] = v[i];
    in_last_a  = last;
    in_valid_a = 1;
    do begin @(negedge clk); guard++; end while (!in_ready_a && guard < 200);
    if (!in_ready_a) begin
      n_chk++;
      $display("FAIL %s_accept: in_ready stayed 0 for 200 cycles", tag);
    end else begin
      qa.push_back(e);
      na++;
    end
    @(posedge clk); #1;
    in_valid_a = 0;
    in_last_a  = 0;
    if (meas) wait_valid_a(6, tag);
  endtask

  task automatic drain_a(input string tag);
    int guard = 0;
    while (qa.size() != 0 && guard < 500) begin @(negedge clk); guard++; end
    chk({tag, "_drained"}, qa.size(), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_b(input int s, input bit last, input string tag);
    exp_t e;
    int lat = 0;
    e.idx = 0; e.mx = s; e.last = last; e.cnt = sat_cnt(nb, 3);
    @(posedge clk); #1;
    in_data_b[0] = s;
    in_last_b    = last;
    in_valid_b   = 1;
    do begin @(negedge clk); lat++; end while (!in_ready_b && lat < 200);
    qb.push_back(e);
    nb++;
    @(posedge clk); #1;
    in_valid_b = 0;
    in_last_b  = 0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!out_valid_b && lat < 100);
    chk({tag, "_latency"}, lat, 1);
  endtask

  initial begin
    int v[6];
    int bi, bm;
    int vq[$];

    // Reset state
    reset_a("rst0");

    // Directed vectors
    v = '{3, -7, 12, 12, 0, 5};
    send_a(v, 0, 1, "dir1");
    drain_a("dir1");
    chk("dir1_count_after", out_count_a, 1);

    v = '{-9, -2, -2, -100, -50, -3};
    send_a(v, 0, 1, "neg");
    drain_a("neg");

    // Backpressure in HOLD with a competing input vector
    out_ready_a = 0;
    v = '{7, 100, -100, 100, 99, 1};
    vq.delete();
    for (int i = 0; i < 6; i++) vq.push_back(v[i]);
    ref_argmax(vq, bi, bm);
    send_a(v, 1, 1, "bp");
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) in_data_a[i] = rnd_score();
    in_valid_a = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", out_valid_a, 1);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_index", out_index_a, bi);
      chk("bp_max", longint'($signed(out_max_a)), bm);
      chk("bp_last", out_last_a, 1);
    end
    @(posedge clk); #1;
    out_ready_a = 1;
    in_valid_a  = 0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", in_ready_a, 1);
    chk("bp_valid_after", out_valid_a, 0);
    chk("bp_count_after", out_count_a, 3);

    // Reset mid-scan, then a fresh vector
    for (int i = 0; i < 6; i++) v[i] = rnd_score();
    send_a(v, 0, 0, "scanrst");
    repeat (2) @(posedge clk);
    reset_a("scanrst");
    for (int i = 0; i < 6; i++) v[i] = rnd_score();
    send_a(v, 0, 1, "post_scanrst");
    drain_a("post_scanrst");

    // Reset while holding a result
    out_ready_a = 0;
    for (int i = 0; i < 6; i++) v[i] = rnd_score();
    send_a(v, 1, 1, "holdrst");
    reset_a("holdrst");
    out_ready_a = 1;
    for (int i = 0; i < 6; i++) v[i] = rnd_score();
    send_a(v, 0, 1, "post_holdrst");
    drain_a("post_holdrst");

    // Eight back-to-back vectors, last flag on the eighth
    reset_a("b2b");
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6; i++) v[i] = rnd_score();
      send_a(v, k == 7, 0, "b2b");
    end
    drain_a("b2b");
    chk("b2b_final_count", out_count_a, 8);

    // Randomized run with random backpressure
    fork
      begin
        int rv[6];
        for (int k = 0; k < 30; k++) begin
          for (int i = 0; i < 6; i++) rv[i] = rnd_score();
          send_a(rv, ($urandom_range(0, 3) == 0), 0, "rand");
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready_a = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready_a = 1;
    drain_a("rand");
    chk("rand_final_count", out_count_a, 38);

    // One-class instance with saturating 2-bit counter
    @(posedge clk); #1;
    rst_b = 1;
    @(posedge clk); #1;
    rst_b = 0;
    @(negedge clk);
    chk("b_rst_in_ready", in_ready_b, 1);
    chk("b_rst_out_valid", out_valid_b, 0);
    chk("b_rst_out_count", out_count_b, 0);
    for (int k = 0; k < 5; k++) send_b(rnd_score(), k == 4, "one");
    begin
      int guard = 0;
      while (qb.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
    end
    chk("b_drained", qb.size(), 0);
    @(posedge clk);
    @(negedge clk);
    chk("b_final_count", out_count_b, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
